fib_scheduler: RTL and testbench



---
 rtl/fib_sched_pkg.sv | 32 +++
 rtl/fib_pair_step.sv | 50 +++++
 rtl/fib_scheduler.sv | 150 +++++++++++++++
 tb/tb_fib_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_sched_pkg.sv
// Shared types and helpers for the Fibonacci scheduler: FSM state encoding,
// sequence seed values and the round-robin next-grant search.
package fib_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int FIB_F0 = 1;
   localparam int FIB_F1 = 1;

   // First requester with valid set, searching from ptr+1 upward and wrapping
   // modulo n. Returns ptr when nothing is valid (caller checks for any valid).
   function automatic int rr_next_grant(input logic [7:0] valid, input int ptr, input int n);
      int g;
      int c;
      logic found;
      g     = ptr;
      found = 1'b0;
      for (int i = 1; i <= n; i++) begin
         c = (ptr + i) % n;
         if (!found && valid[c]) begin
            g     = c;
            found = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/fib_pair_step.sv
// Double-rate Fibonacci pair datapath: holds (a,b) = (F(2k), F(2k+1)) and
// sticky overflow flags; each step advances k by one.
module fib_pair_step
   import fib_sched_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             load_i,
   input  logic             step_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             a_ovf_o,
   output logic             b_ovf_o
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             a_ovf_q;
   logic             b_ovf_q;
   logic [WIDTH:0]   sum_ab;
   logic [WIDTH+1:0] sum_a2b;

   // Next pair: a' = a+b, b' = a+2b, kept wide so carries out of WIDTH are visible
   always_comb begin
      sum_ab  = {1'b0, a_q} + {1'b0, b_q};
      sum_a2b = {2'b00, a_q} + {1'b0, b_q, 1'b0};
   end

   // Pair registers: seeded on load, advanced on step, otherwise held
   always_ff @(posedge clk) begin
      if (load_i) begin
         a_q     <= WIDTH'(FIB_F0);
         b_q     <= WIDTH'(FIB_F1);
         a_ovf_q <= 1'b0;
         b_ovf_q <= 1'b0;
      end else if (step_i) begin
         a_q     <= sum_ab[WIDTH-1:0];
         b_q     <= sum_a2b[WIDTH-1:0];
         a_ovf_q <= a_ovf_q | b_ovf_q | sum_ab[WIDTH];
         b_ovf_q <= a_ovf_q | b_ovf_q | (|sum_a2b[WIDTH+1:WIDTH]);
      end
   end

   assign a_o     = a_q;
   assign b_o     = b_q;
   assign a_ovf_o = a_ovf_q;
   assign b_ovf_o = b_ovf_q;

endmodule

// File: rtl/fib_scheduler.sv
// Round-robin scheduler sharing one double-rate Fibonacci datapath between
// NUM_REQ requesters. Optional macro FIB_SCHEDULER_PERF_EN adds per-requester
// saturating counters of completed response handshakes on perf_done.
module fib_scheduler
   import fib_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 16,
   parameter int IDX_W   = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*IDX_W-1:0]    req_idx,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [WIDTH-1:0]            rsp_num,
   output logic                        rsp_ovf
`ifdef FIB_SCHEDULER_PERF_EN
   ,output logic [NUM_REQ*16-1:0]      perf_done
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   gnt_q, gnt_d;
   logic [IDX_W-2:0]  steps_q, steps_d;
   logic              odd_q, odd_d;
   logic [7:0]        valid8;
   logic [ID_W-1:0]   grant;
   logic [IDX_W-1:0]  idx_sel;
   logic              load, step;
   logic [WIDTH-1:0]  dp_a, dp_b;
   logic              dp_a_ovf, dp_b_ovf;

   fib_pair_step #(.WIDTH(WIDTH)) u_pair (
      .clk     (clk),
      .load_i  (load),
      .step_i  (step),
      .a_o     (dp_a),
      .b_o     (dp_b),
      .a_ovf_o (dp_a_ovf),
      .b_ovf_o (dp_b_ovf)
   );

   // Candidate grant and its requested index, searched from the pointer onward
   always_comb begin
      valid8                = '0;
      valid8[NUM_REQ-1:0]   = req_valid;
      grant                 = ID_W'(rr_next_grant(valid8, int'(ptr_q), NUM_REQ));
      idx_sel               = req_idx[int'(grant)*IDX_W +: IDX_W];
   end

   // Next-state, request accept and datapath sequencing
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      steps_d   = steps_q;
      odd_d     = odd_q;
      req_ready = '0;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            // rst gating keeps req_ready low while reset is held
            if (!rst && (|req_valid)) begin
               req_ready[grant] = 1'b1;
               load             = 1'b1;
               gnt_d            = grant;
               ptr_d            = grant;
               odd_d            = idx_sel[0];
               steps_d          = idx_sel[IDX_W-1:1];
               state_d          = (idx_sel[IDX_W-1:1] != '0) ? RUN : RESP;
            end
         end
         RUN: begin
            step    = 1'b1;
            steps_d = steps_q - 1'b1;
            if (steps_q == (IDX_W-1)'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers; pointer resets so requester 0 is searched first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= ID_W'(NUM_REQ - 1);
         gnt_q   <= '0;
         steps_q <= '0;
         odd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         steps_q <= steps_d;
         odd_q   <= odd_d;
      end
   end

   // Response fields are zero outside RESP and stable (datapath frozen) inside it
   always_comb begin
      rsp_valid = (state_q == RESP);
      rsp_num   = '0;
      rsp_ovf   = 1'b0;
      rsp_id    = '0;
      if (rsp_valid) begin
         rsp_num = odd_q ? dp_b : dp_a;
         rsp_ovf = odd_q ? dp_b_ovf : dp_a_ovf;
         rsp_id  = gnt_q;
      end
   end

`ifdef FIB_SCHEDULER_PERF_EN
   logic [15:0] perf_q [NUM_REQ];

   // Count completed handshakes per requester, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            perf_q[i] <= '0;
         end
      end else if (rsp_valid && rsp_ready && (perf_q[gnt_q] != 16'hFFFF)) begin
         perf_q[gnt_q] <= perf_q[gnt_q] + 16'd1;
      end
   end

   // Flatten counters onto the output bus
   always_comb begin
      perf_done = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         perf_done[i*16 +: 16] = perf_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fib_scheduler.sv
// Self-checking bench for fib_scheduler: directed cases plus randomized
// traffic checked against a plain-arithmetic Fibonacci / round-robin model.
module tb_fib_scheduler;

   localparam int NR = 2;
   localparam int IW = 5;
   localparam int W  = 16;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*IW-1:0]  req_idx;
   logic [NR-1:0]     req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [0:0]        rsp_id;
   logic [W-1:0]      rsp_num;
   logic              rsp_ovf;
`ifdef FIB_SCHEDULER_PERF_EN
   logic [NR*16-1:0]  perf_done;
`endif

   int checks = 0;
   int errors = 0;
   int last_g = NR - 1;

   fib_scheduler #(.NUM_REQ(NR), .WIDTH(W), .IDX_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_idx   (req_idx),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_num   (rsp_num),
      .rsp_ovf   (rsp_ovf)
`ifdef FIB_SCHEDULER_PERF_EN
      ,.perf_done (perf_done)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // True (untruncated) Fibonacci term with F(0)=F(1)=1
   function automatic longint ref_fib(input int idx);
      longint a, b, c;
      a = 1;
      b = 1;
      for (int k = 2; k <= idx; k++) begin
         c = a + b;
         a = b;
         b = c;
      end
      return (idx == 0) ? a : b;
   endfunction

   function automatic logic [W-1:0] ref_num(input int idx);
      longint v;
      v = ref_fib(idx);
      return v[W-1:0];
   endfunction

   function automatic logic ref_ovf(input int idx);
      return ref_fib(idx) >= 64'd65536;
   endfunction

   // Round-robin rule: first pending requester after the last one granted
   function automatic int pick(input logic [NR-1:0] pend, input int last);
      int c;
      for (int i = 1; i <= NR; i++) begin
         c = (last + i) % NR;
         if (pend[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int id);
      logic [NR-1:0] e;
      e = '0;
      if (id >= 0) e[id] = 1'b1;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One request from requester id; optional response stall with the other requester pending
   task automatic run_one(input int id, input int idx, input int stall);
      int lat;
      int t;
      logic [W-1:0] num0;
      logic [4:0] iv;
      iv = idx[4:0];
      req_idx[id*IW +: IW] = iv;
      req_valid[id] = 1'b1;
      rsp_ready = (stall == 0);
      #1;
      t = 0;
      while (!req_ready[id] && t < 50) begin
         @(posedge clk); #2;
         t++;
      end
      check("grant_onehot", req_ready, onehot(id));
      if (!req_ready[id]) begin
         req_valid[id] = 1'b0;
         return;
      end
      last_g = id;
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 1 + idx / 2);
      check("rsp_num", rsp_num, ref_num(idx));
      check("rsp_ovf", rsp_ovf, ref_ovf(idx));
      check("rsp_id", rsp_id, id);
      num0 = rsp_num;
      if (stall > 0) begin
         req_idx[(1-id)*IW +: IW] = 5'd3;
         req_valid[1-id] = 1'b1;
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", rsp_valid, 1);
            check("stall_num", rsp_num, num0);
            check("stall_id", rsp_id, id);
            check("stall_no_grant", req_ready, 0);
         end
         req_valid[1-id] = 1'b0;
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("rsp_done", rsp_valid, 0);
   endtask

   logic [NR-1:0] pend;
   int  pidx [NR];
   int  have_if, if_id, if_idx, acc_c, seen, acc_id, g, gcnt, exp_g;
   logic [4:0] iv5;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_idx   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_num", rsp_num, 0);
      check("reset_rsp_ovf", rsp_ovf, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_req_ready", req_ready, 0);
      rst = 1'b0;
      last_g = NR - 1;
      @(posedge clk); #1;

      // Continuous requests from both: grants must alternate starting at 0
      req_idx[0*IW +: IW] = 5'd4;
      req_idx[1*IW +: IW] = 5'd5;
      req_valid = 2'b11;
      exp_g = 0;
      gcnt  = 0;
      for (int c = 0; c < 100 && gcnt < 4; c++) begin
         #1;
         if (req_ready != '0) begin
            check("alt_grant", req_ready, onehot(exp_g));
            last_g = exp_g;
            exp_g  = 1 - exp_g;
            gcnt++;
         end
         if (rsp_valid) begin
            check("alt_num", rsp_num, ref_num(rsp_id[0] ? 5 : 4));
         end
         @(posedge clk);
      end
      check("alt_grant_count", gcnt, 4);
      #1;
      req_valid = '0;
      repeat (8) @(posedge clk);
      #1;
      check("alt_drained", rsp_valid, 0);

      run_one(0, 0, 0);
      run_one(0, 1, 0);
      run_one(1, 10, 0);
      run_one(1, 11, 0);
      run_one(0, 23, 0);
      run_one(1, 24, 0);
      run_one(0, 31, 0);
      run_one(1, 6, 5);

      // Reset in the middle of a long computation
      req_idx[0*IW +: IW] = 5'd20;
      req_valid[0] = 1'b1;
      #1;
      check("rst_test_grant", req_ready, onehot(pick(2'b01, last_g)));
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      req_valid[1] = 1'b1;
      rst = 1'b1;
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_req_ready", req_ready, 0);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      rst = 1'b0;
      last_g = NR - 1;
      repeat (12) @(posedge clk);
      #1;
      check("lost_request", rsp_valid, 0);
      run_one(0, 2, 0);

      // Randomized traffic against the round-robin / Fibonacci model
      pend    = '0;
      have_if = 0;
      acc_id  = -1;
      if_id   = 0;
      if_idx  = 0;
      acc_c   = 0;
      seen    = 0;
      for (int r = 0; r < NR; r++) pidx[r] = 0;
      for (int c = 0; c < 600; c++) begin
         if (acc_id >= 0) begin
            req_valid[acc_id] = 1'b0;
            acc_id = -1;
         end
         for (int r = 0; r < NR; r++) begin
            if (!pend[r] && $urandom_range(0, 2) == 0) begin
               pend[r] = 1'b1;
               pidx[r] = $urandom_range(0, 31);
               iv5 = pidx[r][4:0];
               req_idx[r*IW +: IW] = iv5;
               req_valid[r] = 1'b1;
            end
         end
         rsp_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (have_if != 0) begin
            check("busy_no_grant", req_ready, 0);
         end else begin
            g = pick(pend, last_g);
            check("rr_grant", req_ready, onehot(g));
            if (g >= 0 && req_ready == onehot(g)) begin
               have_if = 1;
               if_id   = g;
               if_idx  = pidx[g];
               acc_c   = c;
               seen    = 0;
               pend[g] = 1'b0;
               acc_id  = g;
               last_g  = g;
            end
         end
         if (rsp_valid) begin
            check("rsp_expected", have_if, 1);
            if (seen == 0) begin
               check("rnd_latency", c - acc_c, 1 + if_idx / 2);
               seen = 1;
            end
            check("rnd_id", rsp_id, if_id);
            check("rnd_num", rsp_num, ref_num(if_idx));
            check("rnd_ovf", rsp_ovf, ref_ovf(if_idx));
            if (rsp_ready) have_if = 0;
         end else if (have_if != 0 && seen != 0) begin
            check("rnd_rsp_held", rsp_valid, 1);
         end else if (have_if != 0 && (c - acc_c) > 17) begin
            check("rnd_rsp_timeout", rsp_valid, 1);
            have_if = 0;
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("final_idle", rsp_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
